// File: rtl/genius_pkg.sv
// Shared definitions for the Genius game: element/sequence geometry, the
// user-entry FSM state type and the packed-sequence element accessor.
package genius_pkg;

   localparam int ELEM_W  = 4;
   localparam int SEQ_LEN = 16;
   localparam int SEQ_W   = ELEM_W * SEQ_LEN;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_PRESS,
      WAIT_RELEASE,
      DONE
   } state_t;

   // Element k of a packed sequence lives at [4k+3:4k].
   function automatic logic [ELEM_W-1:0] seq_elem(input logic [SEQ_W-1:0] seq,
                                                  input logic [3:0]       idx);
      return seq[ELEM_W*idx +: ELEM_W];
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus per-bit debounce: the output level follows the
// synchronized input only after DEBOUNCE_CYCLES consecutive differing samples.
module btn_debounce #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] level
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [CW-1:0]    cnt [WIDTH];

   // Levels reset high: the raw keys are active-low, so high means released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '1;
         sync2 <= '1;
         level <= '1;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] == level[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
               level[i] <= sync2[i];
               cnt[i]   <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/user_entry.sv
// Captures one round of player key presses, compares each against the FPGA
// sequence and reports completion, mismatch or timeout to the control FSM.
module user_entry
   import genius_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int TIMEOUT_TICKS   = 5
) (
   input  logic             CLOCK_50,
   input  logic             reset_n,
   input  logic             start,
   input  logic [3:0]       KEY,
   input  logic [3:0]       round,
   input  logic [SEQ_W-1:0] seq_fpga,
   input  logic             tick_1hz,
   output logic [3:0]       leds,
   output logic [SEQ_W-1:0] user_seq,
   output logic             busy,
   output logic             end_User,
   output logic             end_time,
   output logic             match,
   output state_t           state_dbg
);

   localparam int TW = $clog2(TIMEOUT_TICKS + 1);

   state_t           state, state_n;
   logic [3:0]       key_level;
   logic [3:0]       pressed, pressed_q;
   logic [3:0]       idx, idx_n;
   logic [TW-1:0]    tcnt, tcnt_n;
   logic             mism, mism_n;
   logic             ign, ign_n;
   logic [SEQ_W-1:0] user_seq_n;
   logic             end_user_n, end_time_n, match_n;
   logic             new_press;

   btn_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk   (CLOCK_50),
      .rst_n (reset_n),
      .raw   (KEY),
      .level (key_level)
   );

   assign pressed   = ~key_level;
   assign leds      = pressed;
   assign busy      = (state == WAIT_PRESS) || (state == WAIT_RELEASE);
   assign state_dbg = state;
   assign new_press = (pressed != 4'b0) && (pressed_q == 4'b0);

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         pressed_q <= '0;
         idx       <= '0;
         tcnt      <= '0;
         mism      <= 1'b0;
         ign       <= 1'b0;
         user_seq  <= '0;
         end_User  <= 1'b0;
         end_time  <= 1'b0;
         match     <= 1'b0;
      end else begin
         state     <= state_n;
         pressed_q <= pressed;
         idx       <= idx_n;
         tcnt      <= tcnt_n;
         mism      <= mism_n;
         ign       <= ign_n;
         user_seq  <= user_seq_n;
         end_User  <= end_user_n;
         end_time  <= end_time_n;
         match     <= match_n;
      end
   end

   always_comb begin
      state_n    = state;
      idx_n      = idx;
      tcnt_n     = tcnt;
      mism_n     = mism;
      ign_n      = ign;
      user_seq_n = user_seq;
      end_user_n = end_User;
      end_time_n = end_time;
      match_n    = match;
      if (start) begin
         state_n    = WAIT_PRESS;
         idx_n      = '0;
         tcnt_n     = '0;
         mism_n     = 1'b0;
         ign_n      = 1'b0;
         user_seq_n = '0;
         end_user_n = 1'b0;
         end_time_n = 1'b0;
         match_n    = 1'b0;
      end else begin
         case (state)
            WAIT_PRESS: begin
               if (new_press) begin
                  // Multi-key chords are swallowed: no write, and idx stays put.
                  if ($onehot(pressed)) begin
                     user_seq_n[ELEM_W*idx +: ELEM_W] = pressed;
                     mism_n = mism | (pressed != seq_elem(seq_fpga, idx));
                     tcnt_n = '0;
                     ign_n  = 1'b0;
                  end else begin
                     ign_n = 1'b1;
                  end
                  state_n = WAIT_RELEASE;
               end else if (tick_1hz) begin
                  if (tcnt == TW'(TIMEOUT_TICKS - 1)) begin
                     end_time_n = 1'b1;
                     match_n    = 1'b0;
                     state_n    = DONE;
                  end else begin
                     tcnt_n = tcnt + 1'b1;
                  end
               end
            end
            WAIT_RELEASE: begin
               if (pressed == 4'b0) begin
                  if (ign) begin
                     state_n = WAIT_PRESS;
                  end else if (mism) begin
                     end_user_n = 1'b1;
                     match_n    = 1'b0;
                     state_n    = DONE;
                  end else if (idx == round) begin
                     end_user_n = 1'b1;
                     match_n    = 1'b1;
                     state_n    = DONE;
                  end else begin
                     idx_n   = idx + 1'b1;
                     state_n = WAIT_PRESS;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_user_entry.sv
// Directed bench for user_entry with an event-level model of a round and a
// per-cycle compare process active whenever the DUT has settled.
module tb_user_entry;
   import genius_pkg::*;

   localparam int DEB = 4;
   localparam int TMO = 3;
   localparam logic [63:0] SEQ = 64'h8421_8421_8421_8421;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [3:0]  KEY;
   logic [3:0]  round;
   logic [63:0] seq_fpga;
   logic        tick_1hz;
   logic [3:0]  leds;
   logic [63:0] user_seq;
   logic        busy, end_User, end_time, match;
   state_t      state_dbg;

   int vectors = 0;
   int miscompares = 0;
   bit chk = 1'b0;

   // model state: phase 0 idle, 1 waiting press, 2 waiting release, 3 done
   int          m_phase;
   int          m_idx;
   int          m_ticks;
   bit          m_mism, m_ign;
   logic [63:0] m_seq;
   logic        m_end_user, m_end_time, m_match;
   logic [3:0]  m_leds;

   always #5 clk = ~clk;

   user_entry #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_TICKS(TMO)) dut (
      .CLOCK_50 (clk),
      .reset_n  (reset_n),
      .start    (start),
      .KEY      (KEY),
      .round    (round),
      .seq_fpga (seq_fpga),
      .tick_1hz (tick_1hz),
      .leds     (leds),
      .user_seq (user_seq),
      .busy     (busy),
      .end_User (end_User),
      .end_time (end_time),
      .match    (match),
      .state_dbg(state_dbg)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk) begin
         check("busy", 64'(busy), 64'(m_phase == 1 || m_phase == 2));
         check("end_User", 64'(end_User), 64'(m_end_user));
         check("end_time", 64'(end_time), 64'(m_end_time));
         check("match", 64'(match), 64'(m_match));
         check("user_seq", user_seq, m_seq);
         check("leds", 64'(leds), 64'(m_leds));
      end
   end

   task automatic model_clear();
      m_phase = 0; m_idx = 0; m_ticks = 0; m_mism = 0; m_ign = 0;
      m_seq = '0; m_end_user = 0; m_end_time = 0; m_match = 0; m_leds = '0;
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1 chk = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk = 1'b0;
   endtask

   task automatic do_start(input logic [3:0] r);
      @(posedge clk); #1;
      round = r;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", 64'(busy), 64'd1);
      m_phase = 1; m_idx = 0; m_ticks = 0; m_mism = 0; m_ign = 0;
      m_seq = '0; m_end_user = 0; m_end_time = 0; m_match = 0;
      settle(2);
   endtask

   task automatic press(input logic [3:0] v);
      KEY = ~v;
      m_leds = v;
      if (m_phase == 1) begin
         if ($countones(v) == 1) begin
            m_seq[4*m_idx +: 4] = v;
            if (v != SEQ[4*m_idx +: 4]) m_mism = 1;
            m_ticks = 0;
            m_ign = 0;
         end else begin
            m_ign = 1;
         end
         m_phase = 2;
      end
      settle(DEB + 8);
   endtask

   task automatic release_keys();
      KEY = 4'hF;
      m_leds = '0;
      if (m_phase == 2) begin
         if (m_ign) m_phase = 1;
         else if (m_mism) begin
            m_end_user = 1; m_match = 0; m_phase = 3;
         end else if (m_idx == int'(round)) begin
            m_end_user = 1; m_match = 1; m_phase = 3;
         end else begin
            m_idx++; m_phase = 1;
         end
      end
      settle(DEB + 8);
   endtask

   task automatic tick();
      @(posedge clk); #1;
      tick_1hz = 1'b1;
      @(posedge clk); #1;
      tick_1hz = 1'b0;
      if (m_phase == 1) begin
         m_ticks++;
         if (m_ticks == TMO) begin
            m_end_time = 1; m_match = 0; m_phase = 3;
         end
      end
      settle(1);
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; KEY = 4'hF; round = 4'd0;
      seq_fpga = SEQ; tick_1hz = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check("reset_user_seq", user_seq, 64'h0);
      check("reset_flags", {60'h0, busy, end_User, end_time, match}, 64'h0);
      reset_n = 1'b1;
      settle(2);

      // full matching round of three elements
      do_start(4'd2);
      press(4'b0001); release_keys();
      press(4'b0010); release_keys();
      press(4'b0100); release_keys();
      check("t1_user_seq_lit", {52'h0, user_seq[11:0]}, 64'h421);
      check("t1_end_lit", {61'h0, end_User, match, end_time}, 64'b110);

      // mismatch on the second element stops capture
      do_start(4'd2);
      press(4'b0001); release_keys();
      press(4'b1000); release_keys();
      press(4'b0100); release_keys();
      check("t2_user_seq_lit", user_seq, 64'h81);
      check("t2_end_lit", {61'h0, end_User, match, end_time}, 64'b100);

      // timeout with no presses
      do_start(4'd3);
      tick(); tick(); tick();
      check("t3_timeout_lit", {61'h0, end_User, match, end_time}, 64'b001);

      // a press resets the timeout budget
      do_start(4'd3);
      tick(); tick();
      press(4'b0001); release_keys();
      tick(); tick();
      check("t3_no_timeout_lit", {62'h0, busy, end_time}, 64'b10);
      tick();
      check("t3_late_timeout_lit", 64'(end_time), 64'd1);

      // bouncing key yields exactly one element
      do_start(4'd2);
      for (int i = 0; i < 10; i++) begin
         KEY = (i % 2 == 0) ? 4'b1110 : 4'b1111;
         repeat (2) @(posedge clk);
         #1;
      end
      press(4'b0001); release_keys();
      press(4'b0010); release_keys();
      check("t4_bounce_lit", {56'h0, user_seq[7:0]}, 64'h21);

      // two-key chord is ignored and does not advance the index
      do_start(4'd2);
      press(4'b0011); release_keys();
      press(4'b0001); release_keys();
      check("t5_chord_lit", user_seq, 64'h1);

      // asynchronous reset mid-round, then a fresh round
      do_start(4'd2);
      press(4'b0001); release_keys();
      press(4'b0010);
      @(posedge clk); #2;
      reset_n = 1'b0;
      #1;
      check("t6_reset_seq", user_seq, 64'h0);
      check("t6_reset_flags", {55'h0, leds, busy, end_User, end_time, match}, 64'h0);
      KEY = 4'hF;
      model_clear();
      repeat (4) @(posedge clk);
      #1 reset_n = 1'b1;
      settle(DEB + 4);
      do_start(4'd2);
      press(4'b0001); release_keys();
      check("t6_restart_lit", user_seq, 64'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
